// File: rtl/egg_timer_countdown.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// egg_timer_countdown
//
// Countdown engine of the egg timer. It captures a programmed MM:SS value in
// BCD from the set-time entry logic and counts it down one second at a time
// once started. When the count reaches 00:00 it flashes the red LEDs until
// the user acknowledges.
//
// Parameters
//   TICKS_PER_SEC : CLOCK_50 cycles per one-second decrement
//   FLASH_TICKS   : CLOCK_50 cycles per LED flash half-period
//
// Ports
//   CLOCK_50  in   system clock; all state changes on its rising edge
//   RESET     in   asynchronous, active-high reset
//   load      in   one-cycle pulse: capture min_bcd/sec_bcd (sanitised)
//   min_bcd   in   [7:4] minute tens, [3:0] minute ones, BCD
//   sec_bcd   in   [7:4] second tens, [3:0] second ones, BCD
//   start     in   one-cycle pulse: begin (or, with pause, toggle) countdown
//   ack       in   one-cycle pulse: leave FLASH
//   min_out   out  current minutes, BCD
//   sec_out   out  current seconds, BCD
//   state_out out  00 IDLE, 01 ARMED, 10 RUN, 11 FLASH
//   done      out  high throughout FLASH
//   LEDR      out  flash pattern (all on / all off)
//
// Build option
//   EGG_TIMER_PAUSE_EN : when defined, start in RUN pauses the countdown
//   into ARMED and keeps both the value and the prescaler count. A later
//   start resumes from that count. A load while ARMED clears the prescaler.
//   When undefined, start in RUN is ignored and every ARMED->RUN
//   transition restarts the prescaler from zero.
//
// All outputs come straight from registers, so there is no combinational
// path from any input to any output.
// -----------------------------------------------------------------------------
module egg_timer_countdown #(
    parameter int TICKS_PER_SEC = 50000000,
    parameter int FLASH_TICKS   = 12500000
) (
    input  logic       CLOCK_50,
    input  logic       RESET,
    input  logic       load,
    input  logic [7:0] min_bcd,
    input  logic [7:0] sec_bcd,
    input  logic       start,
    input  logic       ack,
    output logic [7:0] min_out,
    output logic [7:0] sec_out,
    output logic [1:0] state_out,
    output logic       done,
    output logic [9:0] LEDR
);

    localparam int PRE_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam int FL_W  = (FLASH_TICKS > 1)   ? $clog2(FLASH_TICKS)   : 1;

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICKS_PER_SEC - 1);
    localparam logic [PRE_W-1:0] PRE_ZERO = PRE_W'(0);
    localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1);
    localparam logic [FL_W-1:0]  FL_LAST  = FL_W'(FLASH_TICKS - 1);
    localparam logic [FL_W-1:0]  FL_ZERO  = FL_W'(0);
    localparam logic [FL_W-1:0]  FL_ONE   = FL_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ARMED = 2'b01,
        ST_RUN   = 2'b10,
        ST_FLASH = 2'b11
    } state_t;

    state_t           state_r;
    logic [7:0]       min_r;
    logic [7:0]       sec_r;
    logic [PRE_W-1:0] pre_r;
    logic [FL_W-1:0]  flash_cnt_r;
    logic             done_r;
    logic [9:0]       led_r;

    // Clamp one BCD digit to an upper limit.
    function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] lim);
        return (d > lim) ? lim : d;
    endfunction

    // Minutes accept 00..99; out-of-range nibbles clamp to 9.
    function automatic logic [7:0] sanitise_min(input logic [7:0] v);
        return {clamp_digit(v[7:4], 4'd9), clamp_digit(v[3:0], 4'd9)};
    endfunction

    // Seconds accept 00..59; the tens nibble clamps to 5 and the ones nibble to 9.
    function automatic logic [7:0] sanitise_sec(input logic [7:0] v);
        return {clamp_digit(v[7:4], 4'd5), clamp_digit(v[3:0], 4'd9)};
    endfunction

    // Subtract one second from {min, sec} in BCD. Each digit that is zero
    // wraps to its maximum and borrows from the next digit up.
    function automatic logic [15:0] dec_mmss(input logic [15:0] v);
        logic [3:0] mt;
        logic [3:0] mo;
        logic [3:0] st;
        logic [3:0] so;
        mt = v[15:12];
        mo = v[11:8];
        st = v[7:4];
        so = v[3:0];
        if (so != 4'd0) begin
            so = so - 4'd1;
        end else begin
            so = 4'd9;
            if (st != 4'd0) begin
                st = st - 4'd1;
            end else begin
                st = 4'd5;
                if (mo != 4'd0) begin
                    mo = mo - 4'd1;
                end else begin
                    mo = 4'd9;
                    // 00:00 never reaches this point, because RUN leaves at 00:01.
                    mt = (mt != 4'd0) ? (mt - 4'd1) : 4'd0;
                end
            end
        end
        return {mt, mo, st, so};
    endfunction

    // Countdown FSM together with its prescaler, value and output registers.
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            state_r     <= ST_IDLE;
            min_r       <= 8'h00;
            sec_r       <= 8'h00;
            pre_r       <= PRE_ZERO;
            flash_cnt_r <= FL_ZERO;
            done_r      <= 1'b0;
            led_r       <= 10'h000;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (load) begin
                        min_r   <= sanitise_min(min_bcd);
                        sec_r   <= sanitise_sec(sec_bcd);
                        pre_r   <= PRE_ZERO;
                        state_r <= ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    // load takes priority over start when both arrive together.
                    if (load) begin
                        min_r <= sanitise_min(min_bcd);
                        sec_r <= sanitise_sec(sec_bcd);
                        pre_r <= PRE_ZERO;
                    end else if (start && ({min_r, sec_r} != 16'h0000)) begin
                        state_r <= ST_RUN;
`ifndef EGG_TIMER_PAUSE_EN
                        pre_r   <= PRE_ZERO;
`endif
                    end
                end
                ST_RUN: begin
`ifdef EGG_TIMER_PAUSE_EN
                    if (start) begin
                        // Pause: the value and the prescaler count are both held.
                        state_r <= ST_ARMED;
                    end else
`endif
                    if (pre_r == PRE_LAST) begin
                        pre_r          <= PRE_ZERO;
                        {min_r, sec_r} <= dec_mmss({min_r, sec_r});
                        if ({min_r, sec_r} == 16'h0001) begin
                            state_r     <= ST_FLASH;
                            done_r      <= 1'b1;
                            led_r       <= 10'h3FF;
                            flash_cnt_r <= FL_ZERO;
                        end
                    end else begin
                        pre_r <= pre_r + PRE_ONE;
                    end
                end
                ST_FLASH: begin
                    if (ack) begin
                        state_r     <= ST_IDLE;
                        done_r      <= 1'b0;
                        led_r       <= 10'h000;
                        flash_cnt_r <= FL_ZERO;
                    end else if (flash_cnt_r == FL_LAST) begin
                        flash_cnt_r <= FL_ZERO;
                        led_r       <= ~led_r;
                    end else begin
                        flash_cnt_r <= flash_cnt_r + FL_ONE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign min_out   = min_r;
    assign sec_out   = sec_r;
    assign state_out = state_r;
    assign done      = done_r;
    assign LEDR      = led_r;

endmodule
